// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - FWFT byte FIFO behind a UART receiver with release handshake
module uart_rx_buffer #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_ready,
   output logic              rx_release,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   input  logic              clear_overflow
);

   typedef enum logic {S_WAIT, S_DRAIN} state_t;

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [7:0]        mem [DEPTH];
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              rx_release_q, rx_release_d;
   logic              overflow_q, overflow_d;
   logic              full, push, pop, blocked;

   always_comb begin
      // Full uses the pre-edge count, so a same-edge pop never unblocks a push.
      full         = (count_q == FULL_CNT);
      push         = (state_q == S_WAIT) && rx_ready && !full;
      blocked      = (state_q == S_WAIT) && rx_ready && full;
      pop          = (count_q != '0) && rd_ready;

      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      rx_release_d = push;
      overflow_d   = overflow_q;

      if (push) begin
         state_d  = S_DRAIN;
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end else if (state_q == S_DRAIN && !rx_ready) begin
         state_d  = S_WAIT;
      end

      if (pop) rd_ptr_d = rd_ptr_q + ADDR_W'(1);

      if (push && !pop)      count_d = count_q + (ADDR_W+1)'(1);
      else if (pop && !push) count_d = count_q - (ADDR_W+1)'(1);

      if (blocked)             overflow_d = 1'b1;
      else if (clear_overflow) overflow_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_WAIT;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         rx_release_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         rx_release_q <= rx_release_d;
         overflow_q   <= overflow_d;
      end
   end

   // Storage is not reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (!rst && push) mem[wr_ptr_q] <= rx_data;
   end

   assign rd_data    = mem[rd_ptr_q];
   assign rd_valid   = (count_q != '0);
   assign count      = count_q;
   assign rx_release = rx_release_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - randomized self-checking bench against a queue model
module tb_uart_rx_buffer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = '0;
   logic       rx_ready = 1'b0;
   logic       rx_release;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready = 1'b0;
   logic [4:0] count;
   logic       overflow;
   logic       clear_overflow = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [7:0] q [$];
   bit         taken = 0;
   bit         m_rel = 0;
   bit         m_ovf = 0;
   int         rel_pulses = 0;

   uart_rx_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
      .rx_release(rx_release), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_ready(rd_ready), .count(count), .overflow(overflow),
      .clear_overflow(clear_overflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model by the rules, compare after the edge.
   task automatic step(input bit rdy, input logic [7:0] data, input bit rr,
                       input bit clr, input bit r);
      bit do_pop, do_push, is_full;
      rx_ready = rdy; rx_data = data; rd_ready = rr; clear_overflow = clr; rst = r;
      @(posedge clk);
      if (r) begin
         q.delete(); taken = 0; m_rel = 0; m_ovf = 0;
      end else begin
         is_full = (q.size() == 16);
         do_pop  = (q.size() > 0) && rr;
         do_push = rdy && !taken && !is_full;
         if (rdy && !taken && is_full) m_ovf = 1;
         else if (clr)                 m_ovf = 0;
         m_rel = do_push;
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(data);
         if (do_push) taken = 1;
         else if (!rdy) taken = 0;
      end
      #1;
      check_eq("count", count, q.size());
      check_eq("rd_valid", rd_valid, q.size() != 0);
      if (q.size() != 0) check_eq("rd_data", rd_data, q[0]);
      check_eq("rx_release", rx_release, m_rel);
      check_eq("overflow", overflow, m_ovf);
      if (rx_release) rel_pulses++;
   endtask

   initial begin
      int nsent, nread, gap, budget;
      bit rr;

      #1;
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      check_eq("reset_count", count, 0);
      check_eq("reset_valid", rd_valid, 0);

      // Single byte
      step(1, 8'hA5, 0, 0, 0);
      check_eq("single_rel", rx_release, 1);
      check_eq("single_data", rd_data, 8'hA5);
      step(0, 0, 0, 0, 0);
      check_eq("single_rel_off", rx_release, 0);
      step(0, 0, 1, 0, 0);
      check_eq("single_pop_count", count, 0);

      // Held level yields one push
      rel_pulses = 0;
      for (int i = 0; i < 6; i++) step(1, 8'h3C, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check_eq("held_count", count, 1);
      check_eq("held_pulses", rel_pulses, 1);
      step(0, 0, 1, 0, 0);

      // Fill to full, then back-pressure
      for (int i = 0; i < 16; i++) begin
         step(1, 8'(i), 0, 0, 0);
         step(0, 0, 0, 0, 0);
      end
      check_eq("full_count", count, 16);
      rel_pulses = 0;
      step(1, 8'h10, 0, 0, 0);
      step(1, 8'h10, 0, 0, 0);
      check_eq("bp_ovf", overflow, 1);
      check_eq("bp_head", rd_data, 8'h00);
      step(1, 8'h10, 1, 0, 0);
      check_eq("bp_pop_count", count, 15);
      step(1, 8'h10, 0, 0, 0);
      check_eq("bp_push_count", count, 16);
      step(1, 8'h10, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check_eq("bp_pulses", rel_pulses, 1);
      step(0, 0, 0, 1, 0);
      check_eq("clear_ovf", overflow, 0);
      for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);
      check_eq("tail_byte", count, 0);

      // Random interleave with wrap; order checked independently of the model queue
      nsent = 0; nread = 0; gap = 0; budget = 0;
      while ((nsent < 40 || nread < 40) && budget < 3000) begin
         rr = ($urandom_range(0, 2) != 0);
         if (rd_valid && rr) begin
            check_eq("order", rd_data, 8'h40 + 8'(nread));
            nread++;
         end
         if (nsent < 40 && gap == 0) begin
            step(1, 8'h40 + 8'(nsent), rr, 0, 0);
            if (rx_release) begin
               nsent++;
               gap = $urandom_range(1, 3);
            end
         end else begin
            if (gap > 0) gap--;
            step(0, 0, rr, 0, 0);
         end
         budget++;
      end
      check_eq("wrap_done", budget < 3000, 1);
      check_eq("wrap_ovf", overflow, 0);

      // Simultaneous push and pop at count=3
      for (int i = 0; i < 3; i++) begin
         step(1, 8'h70 + 8'(i), 0, 0, 0);
         step(0, 0, 0, 0, 0);
      end
      step(1, 8'h77, 1, 0, 0);
      check_eq("simul_count", count, 3);
      check_eq("simul_data", rd_data, 8'h71);
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

      // Reset while in drain with five stored
      for (int i = 0; i < 4; i++) begin
         step(1, 8'h20 + 8'(i), 0, 0, 0);
         step(0, 0, 0, 0, 0);
      end
      step(1, 8'h24, 0, 0, 0);
      step(1, 8'h24, 0, 0, 0);
      check_eq("pre_rst_count", count, 5);
      step(0, 0, 0, 0, 1);
      check_eq("rst_count", count, 0);
      check_eq("rst_rel", rx_release, 0);
      step(1, 8'h5A, 0, 0, 0);
      check_eq("post_rst_data", rd_data, 8'h5A);
      step(0, 0, 1, 0, 0);
      check_eq("post_rst_empty", rd_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
